// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// A start/busy/done handshake lets a controller request a conversion and wait for it.
// The four low decimal digits are registered; ovf flags a converted value above 9999.
module bin_to_bcd_seq #(
    parameter int unsigned WIDTH = 14
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [3:0]       d3,
    output logic [3:0]       d2,
    output logic [3:0]       d1,
    output logic [3:0]       d0,
    output logic             ovf
);

    localparam int unsigned DIGITS = 5;
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [WIDTH-1:0]   shreg;
    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shift;
    logic [CNT_W-1:0]   count;
    logic               last_shift;

    // Add 3 to every digit that is 5 or more, then shift in the next binary bit
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_shift  = {bcd_adj[BCD_W-2:0], shreg[WIDTH-1]};
        last_shift = (state == SHIFT) && (count == LAST_CNT);
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = SHIFT;
            SHIFT:   if (count == LAST_CNT) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register with registered busy/done decoded from the next state
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n != IDLE);
            done  <= (state_n == DONE);
        end
    end

    // Datapath: capture on accept, shift while converting, publish on the final shift
    always_ff @(posedge clk) begin
        if (!resetn) begin
            shreg <= '0;
            bcd   <= '0;
            count <= '0;
            d3    <= 4'd0;
            d2    <= 4'd0;
            d1    <= 4'd0;
            d0    <= 4'd0;
            ovf   <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                shreg <= bin;
                bcd   <= '0;
                count <= '0;
            end else if (state == SHIFT) begin
                shreg <= shreg << 1;
                bcd   <= bcd_shift;
                count <= count + CNT_W'(1);
            end
            if (last_shift) begin
                d3  <= bcd_shift[15:12];
                d2  <= bcd_shift[11:8];
                d1  <= bcd_shift[7:4];
                d0  <= bcd_shift[3:0];
                ovf <= |bcd_shift[19:16];
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: expected digits and done cycle go into a
// scoreboard when a start is accepted and are checked when done pulses.
module tb_bin_to_bcd_seq;

    localparam int unsigned WIDTH = 14;

    logic             clk = 1'b0;
    logic             resetn;
    logic             start;
    logic [WIDTH-1:0] bin;
    logic             busy;
    logic             done;
    logic [3:0]       d3, d2, d1, d0;
    logic             ovf;

    typedef struct {
        logic [3:0] d3, d2, d1, d0;
        logic       ovf;
        int         dcyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   total  = 0;
    int   passed = 0;
    int   nfail  = 0;
    int   ndone  = 0;

    bin_to_bcd_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk), .resetn(resetn), .start(start), .bin(bin),
        .busy(busy), .done(done),
        .d3(d3), .d2(d2), .d1(d1), .d0(d0), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Posedge counter used to time done pulses
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int v, input int dc);
        exp_t e;
        int   m;
        m      = v % 10000;
        e.d3   = 4'(m / 1000);
        e.d2   = 4'((m / 100) % 10);
        e.d1   = 4'((m / 10) % 10);
        e.d0   = 4'(m % 10);
        e.ovf  = (v > 9999);
        e.dcyc = dc;
        return e;
    endfunction

    // Advance one cycle; a start seen while idle will be accepted at the next edge
    task automatic step();
        if (resetn && start && !busy) sb.push_back(model(int'(bin), cyc + 15));
        @(negedge clk);
    endtask

    task automatic convert(input int v);
        start = 1'b1;
        bin   = WIDTH'(v);
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200; n++) begin
            if (sb.size() == 0 && !busy) break;
            step();
        end
        check("timeout_pending", 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard consumer: every done pulse must match the oldest accepted request
    always @(negedge clk) begin
        if (resetn && done) begin
            exp_t e;
            ndone++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("d3", 32'(d3), 32'(e.d3));
                check("d2", 32'(d2), 32'(e.d2));
                check("d1", 32'(d1), 32'(e.d1));
                check("d0", 32'(d0), 32'(e.d0));
                check("ovf", 32'(ovf), 32'(e.ovf));
                check("latency", 32'(cyc), 32'(e.dcyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, nd0, ds, last_d;
        resetn = 1'b0;
        start  = 1'b0;
        bin    = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_digits", 32'({d3, d2, d1, d0}), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        resetn = 1'b1;
        step();

        // Zero, with busy width measured
        convert(0);
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) nb++;
            step();
        end
        check("busy_cycles", 32'(nb), 32'd15);

        convert(1234);  wait_idle();
        convert(9999);  wait_idle();
        convert(10000); wait_idle();
        convert(16383); wait_idle();
        convert(42);    wait_idle();

        // Starts during SHIFT and in the DONE cycle are ignored
        nd0 = ndone;
        ds  = -10;
        for (int i = 0; i < 25; i++) begin
            if (i == 0) begin
                start = 1'b1; bin = WIDTH'(500);
            end else if (i == 3 || i == 8 || done) begin
                start = 1'b1; bin = WIDTH'(7);
            end else begin
                start = 1'b0;
            end
            if (done) ds = i;
            if (i == ds + 1) check("idle_after_done1", 32'(busy), 32'd0);
            if (i == ds + 2) check("idle_after_done2", 32'(busy), 32'd0);
            step();
        end
        start = 1'b0;
        check("single_done", 32'(ndone - nd0), 32'd1);
        check("ignored_starts", 32'(sb.size()), 32'd0);

        // Reset aborts a conversion at its sixth shift
        convert(1234); wait_idle();
        convert(8765);
        repeat (5) step();
        resetn = 1'b0;
        sb.delete();
        nd0 = ndone;
        step();
        resetn = 1'b1;
        check("abort_digits", 32'({d3, d2, d1, d0}), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (20) step();
        check("abort_no_done", 32'(ndone - nd0), 32'd0);
        convert(8765); wait_idle();

        // Held start repeats every WIDTH+2 cycles
        start  = 1'b1;
        bin    = WIDTH'(255);
        last_d = -1;
        nd0    = ndone;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                if (last_d >= 0) check("done_spacing", 32'(cyc - last_d), 32'd16);
                last_d = cyc;
            end
            step();
        end
        start = 1'b0;
        wait_idle();
        check("held_done_count", 32'(ndone - nd0 >= 3), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
